// File: rtl/cpu_3_oci_dct_unpacker.sv
// OCI compressed-trace unpacker: replays packed frames of 2-bit trace codes
// one code per cycle, with a one-frame hold register to absorb producer bursts.
//
// state | meaning
// IDLE  | active register empty, nothing presented on the output stream
// SHIFT | active register holds a frame, code at data[1:0] presented
module cpu_3_oci_dct_unpacker #(
    parameter int CODE_W    = 2,
    parameter int MAX_CODES = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAX_CODES*CODE_W-1:0] dct_buffer,
    input  logic [3:0]                  dct_count,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CODE_W-1:0]           out_code,
    output logic [3:0]                  out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic [15:0]                 frame_count
);

    localparam int DATA_W = MAX_CODES * CODE_W;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] act_data;
    logic [3:0]        act_rem;
    logic [3:0]        act_idx;
    logic [DATA_W-1:0] hold_data;
    logic [3:0]        hold_cnt;
    logic              hold_valid;

    logic              code_hs;
    logic              last_hs;
    logic              accept;
    logic [DATA_W-1:0] shifted;

    assign in_ready  = !hold_valid && !reset && !flush;
    assign out_valid = (state == SHIFT);
    assign out_code  = act_data[CODE_W-1:0];
    assign out_index = act_idx;
    assign out_last  = (act_rem == 4'd1);
    assign busy      = (state == SHIFT) || hold_valid;

    assign code_hs = out_valid && out_ready;
    assign last_hs = code_hs && (act_rem == 4'd1);
    // Zero-length frames complete the handshake but are never stored.
    assign accept  = in_valid && in_ready && (dct_count != 4'd0);
    assign shifted = {{CODE_W{1'b0}}, act_data[DATA_W-1:CODE_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            act_data    <= '0;
            act_rem     <= '0;
            act_idx     <= '0;
            hold_data   <= '0;
            hold_cnt    <= '0;
            hold_valid  <= 1'b0;
            frame_count <= '0;
        end else begin
            // A final-code handshake still counts even when flush discards the rest.
            if (last_hs) begin
                frame_count <= frame_count + 16'd1;
            end

            if (flush) begin
                state      <= IDLE;
                act_data   <= '0;
                act_rem    <= '0;
                act_idx    <= '0;
                hold_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= SHIFT;
                            act_data <= dct_buffer;
                            act_rem  <= dct_count;
                            act_idx  <= '0;
                        end
                    end
                    SHIFT: begin
                        if (last_hs) begin
                            if (hold_valid) begin
                                act_data   <= hold_data;
                                act_rem    <= hold_cnt;
                                act_idx    <= '0;
                                hold_valid <= 1'b0;
                            end else if (accept) begin
                                act_data <= dct_buffer;
                                act_rem  <= dct_count;
                                act_idx  <= '0;
                            end else begin
                                state    <= IDLE;
                                act_data <= shifted;
                                act_rem  <= '0;
                                act_idx  <= '0;
                            end
                        end else if (code_hs) begin
                            act_data <= shifted;
                            act_rem  <= act_rem - 4'd1;
                            act_idx  <= act_idx + 4'd1;
                        end

                        // in_ready already implies the hold register is empty.
                        if (accept && !last_hs) begin
                            hold_data  <= dct_buffer;
                            hold_cnt   <= dct_count;
                            hold_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
